// File: rtl/dense_kernel_step_sequencer_pkg.sv
// Shared constants and FSM state type for the dense kernel step sequencer.
package NVP_v1_constants;

  localparam int STEP_BIT_WIDTH  = 8;
  localparam int PIXEL_BIT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACT,
    ISSUE
  } dense_seq_state_t;

endpackage

// File: rtl/dense_kernel_step_sequencer_step_counter.sv
// Up-counter with a programmable terminal value: wraps to zero after reaching it.
module step_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] terminal,
  output logic [WIDTH-1:0] o_value,
  output logic             o_at_terminal
);

  assign o_at_terminal = (o_value == terminal);

  // load clears to the first step of a new layer; inc advances and wraps at terminal
  always_ff @(posedge clk) begin
    if (reset) begin
      o_value <= '0;
    end else if (load) begin
      o_value <= '0;
    end else if (inc) begin
      o_value <= o_at_terminal ? '0 : o_value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/dense_kernel_step_sequencer.sv
// Holds each activation channel group and replays it once per kernel step to the PE arrays,
// generating weight-line addresses, step indices, finalize flags and layer completion.
module dense_kernel_step_sequencer
  import NVP_v1_constants::*;
#(
  parameter int ACTIVATION_BIT_WIDTH     = 8,
  parameter int NUMBER_OF_READ_STREAMS   = 4,
  parameter int WEIGHT_LINE_BUFFER_DEPTH = 1024,
  localparam int ADDR_W = $clog2(WEIGHT_LINE_BUFFER_DEPTH),
  localparam int DATA_W = ACTIVATION_BIT_WIDTH * NUMBER_OF_READ_STREAMS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_start,
  input  logic [STEP_BIT_WIDTH-1:0]  i_num_kernel_steps,
  input  logic [STEP_BIT_WIDTH-1:0]  i_num_channel_steps,
  input  logic [PIXEL_BIT_WIDTH-1:0] i_num_pixels,
  input  logic [DATA_W-1:0]          i_act_data,
  input  logic                       i_act_valid,
  output logic                       o_act_ready,
  output logic [DATA_W-1:0]          o_pe_data,
  output logic                       o_pe_valid,
  input  logic                       i_pe_ready,
  output logic [ADDR_W-1:0]          o_weight_addr,
  output logic [STEP_BIT_WIDTH-1:0]  o_kernel_step,
  output logic [STEP_BIT_WIDTH-1:0]  o_channel_step,
  output logic                       o_last_channel_step,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_cfg_error
);

  dense_seq_state_t state, state_next;

  logic [STEP_BIT_WIDTH-1:0]    cfg_k, cfg_c;
  logic [PIXEL_BIT_WIDTH-1:0]   cfg_p;
  logic [STEP_BIT_WIDTH-1:0]    k_term, c_term;
  logic [PIXEL_BIT_WIDTH-1:0]   p_term;
  logic [2*STEP_BIT_WIDTH-1:0]  cfg_product;
  logic [STEP_BIT_WIDTH-1:0]    k_value, c_value;
  logic                         k_last, c_last, p_last;
  logic                         cfg_bad, start_accept, layer_start;
  logic                         pe_fire, act_fire, last_beat;
  logic [DATA_W-1:0]            pe_data;
  logic [ADDR_W-1:0]            weight_addr;
  logic                         done_q, cfg_error_q;

  assign cfg_product = (2*STEP_BIT_WIDTH)'(i_num_kernel_steps) *
                       (2*STEP_BIT_WIDTH)'(i_num_channel_steps);
  assign cfg_bad = (i_num_kernel_steps == '0) || (i_num_channel_steps == '0) ||
                   (i_num_pixels == '0) ||
                   (32'(cfg_product) > 32'(WEIGHT_LINE_BUFFER_DEPTH));

  // The done cycle already reads as IDLE, so a start there must be masked explicitly
  assign start_accept = (state == IDLE) && i_start && !done_q;
  assign layer_start  = start_accept && !cfg_bad;

  assign k_term = cfg_k - STEP_BIT_WIDTH'(1);
  assign c_term = cfg_c - STEP_BIT_WIDTH'(1);
  assign p_term = cfg_p - PIXEL_BIT_WIDTH'(1);

  assign pe_fire   = (state == ISSUE) && i_pe_ready;
  assign act_fire  = o_act_ready && i_act_valid;
  assign last_beat = k_last && c_last && p_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A new group is taken during ISSUE only when the final kernel replay leaves this cycle
  always_comb begin
    state_next  = state;
    o_act_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (layer_start) state_next = WAIT_ACT;
      end
      WAIT_ACT: begin
        o_act_ready = 1'b1;
        if (i_act_valid) state_next = ISSUE;
      end
      ISSUE: begin
        o_act_ready = k_last && i_pe_ready && !last_beat;
        if (i_pe_ready) begin
          if (last_beat) begin
            state_next = IDLE;
          end else if (k_last) begin
            state_next = i_act_valid ? ISSUE : WAIT_ACT;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_k       <= '0;
      cfg_c       <= '0;
      cfg_p       <= '0;
      cfg_error_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= pe_fire && last_beat;
      if (start_accept) begin
        cfg_k       <= i_num_kernel_steps;
        cfg_c       <= i_num_channel_steps;
        cfg_p       <= i_num_pixels;
        cfg_error_q <= cfg_bad;
      end
    end
  end

  // Address tracks c*K+k by counting consumed beats, restarting at each pixel boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      pe_data     <= '0;
      weight_addr <= '0;
    end else begin
      if (act_fire) pe_data <= i_act_data;
      if (layer_start) begin
        weight_addr <= '0;
      end else if (pe_fire) begin
        weight_addr <= (k_last && c_last) ? '0 : weight_addr + ADDR_W'(1);
      end
    end
  end

  step_counter #(.WIDTH(STEP_BIT_WIDTH)) u_kernel_counter (
    .clk           (clk),
    .reset         (reset),
    .load          (layer_start),
    .inc           (pe_fire),
    .terminal      (k_term),
    .o_value       (k_value),
    .o_at_terminal (k_last)
  );

  step_counter #(.WIDTH(STEP_BIT_WIDTH)) u_channel_counter (
    .clk           (clk),
    .reset         (reset),
    .load          (layer_start),
    .inc           (pe_fire && k_last),
    .terminal      (c_term),
    .o_value       (c_value),
    .o_at_terminal (c_last)
  );

  step_counter #(.WIDTH(PIXEL_BIT_WIDTH)) u_pixel_counter (
    .clk           (clk),
    .reset         (reset),
    .load          (layer_start),
    .inc           (pe_fire && k_last && c_last),
    .terminal      (p_term),
    .o_value       (),
    .o_at_terminal (p_last)
  );

  assign o_pe_data           = pe_data;
  assign o_pe_valid          = (state == ISSUE);
  assign o_weight_addr       = weight_addr;
  assign o_kernel_step       = k_value;
  assign o_channel_step      = c_value;
  assign o_last_channel_step = (state == ISSUE) && c_last;
  assign o_busy              = (state != IDLE);
  assign o_done              = done_q;
  assign o_cfg_error         = cfg_error_q;

endmodule

// File: tb/tb_dense_kernel_step_sequencer.sv
// Directed and randomized checks of the dense kernel step sequencer against a
// per-layer list of expected PE beats derived from K, C, P and the activation stream.
module tb_dense_kernel_step_sequencer;
  import NVP_v1_constants::*;

  localparam int ACT_W  = 8;
  localparam int N      = 4;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int DATA_W = ACT_W * N;
  localparam int CYCLE_LIMIT = 5000;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       i_start;
  logic [STEP_BIT_WIDTH-1:0]  i_num_kernel_steps;
  logic [STEP_BIT_WIDTH-1:0]  i_num_channel_steps;
  logic [PIXEL_BIT_WIDTH-1:0] i_num_pixels;
  logic [DATA_W-1:0]          i_act_data;
  logic                       i_act_valid;
  logic                       o_act_ready;
  logic [DATA_W-1:0]          o_pe_data;
  logic                       o_pe_valid;
  logic                       i_pe_ready;
  logic [ADDR_W-1:0]          o_weight_addr;
  logic [STEP_BIT_WIDTH-1:0]  o_kernel_step;
  logic [STEP_BIT_WIDTH-1:0]  o_channel_step;
  logic                       o_last_channel_step;
  logic                       o_busy;
  logic                       o_done;
  logic                       o_cfg_error;

  dense_kernel_step_sequencer #(
    .ACTIVATION_BIT_WIDTH     (ACT_W),
    .NUMBER_OF_READ_STREAMS   (N),
    .WEIGHT_LINE_BUFFER_DEPTH (DEPTH)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .i_start             (i_start),
    .i_num_kernel_steps  (i_num_kernel_steps),
    .i_num_channel_steps (i_num_channel_steps),
    .i_num_pixels        (i_num_pixels),
    .i_act_data          (i_act_data),
    .i_act_valid         (i_act_valid),
    .o_act_ready         (o_act_ready),
    .o_pe_data           (o_pe_data),
    .o_pe_valid          (o_pe_valid),
    .i_pe_ready          (i_pe_ready),
    .o_weight_addr       (o_weight_addr),
    .o_kernel_step       (o_kernel_step),
    .o_channel_step      (o_channel_step),
    .o_last_channel_step (o_last_channel_step),
    .o_busy              (o_busy),
    .o_done              (o_done),
    .o_cfg_error         (o_cfg_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0]         addr;
    logic [STEP_BIT_WIDTH-1:0] k;
    logic [STEP_BIT_WIDTH-1:0] c;
    logic                      last;
    logic [DATA_W-1:0]         data;
  } beat_t;

  beat_t             exp_q[$];
  logic [DATA_W-1:0] act_list[$];
  int                n_cmp  = 0;
  int                n_fail = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Every pixel walks channel groups in order, and each group is replayed for k = 0..K-1
  task automatic build_reference(input int kk, input int cc, input int pp);
    beat_t b;
    act_list.delete();
    exp_q.delete();
    for (int g = 0; g < cc * pp; g++) act_list.push_back(DATA_W'($urandom));
    for (int p = 0; p < pp; p++)
      for (int c = 0; c < cc; c++)
        for (int k = 0; k < kk; k++) begin
          b.addr = ADDR_W'(c * kk + k);
          b.k    = STEP_BIT_WIDTH'(k);
          b.c    = STEP_BIT_WIDTH'(c);
          b.last = (c == cc - 1);
          b.data = act_list[p * cc + c];
          exp_q.push_back(b);
        end
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_act_ready"}, o_act_ready, 0);
    checkOutput({tag, "_pe_data"}, o_pe_data, 0);
    checkOutput({tag, "_pe_valid"}, o_pe_valid, 0);
    checkOutput({tag, "_addr"}, o_weight_addr, 0);
    checkOutput({tag, "_k"}, o_kernel_step, 0);
    checkOutput({tag, "_c"}, o_channel_step, 0);
    checkOutput({tag, "_last"}, o_last_channel_step, 0);
    checkOutput({tag, "_busy"}, o_busy, 0);
    checkOutput({tag, "_done"}, o_done, 0);
    checkOutput({tag, "_cfg_error"}, o_cfg_error, 0);
  endtask

  task automatic start_layer(input int kk, input int cc, input int pp);
    @(negedge clk);
    i_num_kernel_steps  = STEP_BIT_WIDTH'(kk);
    i_num_channel_steps = STEP_BIT_WIDTH'(cc);
    i_num_pixels        = PIXEL_BIT_WIDTH'(pp);
    i_act_valid         = 1'b0;
    i_start             = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic bad_start(input string tag, input int kk, input int cc, input int pp);
    start_layer(kk, cc, pp);
    checkOutput({tag, "_cfg_error"}, o_cfg_error, 1);
    checkOutput({tag, "_busy"}, o_busy, 0);
    checkOutput({tag, "_act_ready"}, o_act_ready, 0);
  endtask

  // ready_mode: 0 always, 1 random, 2 three-cycle stall on the second beat
  // valid_mode: 0 always, 1 random
  task automatic applyStimulus(input string tag, input int kk, input int cc, input int pp,
                               input int ready_mode, input int valid_mode,
                               input int abort_after, input bit start_on_done);
    int  next_idx = 0, fired = 0, cycles = 0, groups, total_beats;
    int  stall_left = 0, first_valid = -1, last_fire = -1;
    bit  stall_armed, done_exp = 0, pe_valid_exp = 0, seen_done = 0, stop = 0, aborted = 0;
    bit  act_fire, pe_fire;
    beat_t front;

    build_reference(kk, cc, pp);
    groups      = cc * pp;
    total_beats = exp_q.size();
    stall_armed = (ready_mode == 2);
    start_layer(kk, cc, pp);
    checkOutput({tag, "_start_busy"}, o_busy, 1);
    checkOutput({tag, "_start_cfg_error"}, o_cfg_error, 0);
    checkOutput({tag, "_start_pe_valid"}, o_pe_valid, 0);
    checkOutput({tag, "_start_act_ready"}, o_act_ready, 1);

    while (!stop) begin
      if (stall_armed && fired == 1) begin
        stall_left  = 3;
        stall_armed = 0;
      end
      case (ready_mode)
        0:       i_pe_ready = 1'b1;
        1:       i_pe_ready = ($urandom_range(0, 3) != 0);
        default: i_pe_ready = (stall_left == 0);
      endcase
      if (stall_left > 0) stall_left--;
      i_act_valid = (valid_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      i_act_data  = (next_idx < groups) ? act_list[next_idx] : DATA_W'($urandom);
      i_start     = start_on_done && done_exp;
      #1;

      checkOutput({tag, "_done"}, o_done, done_exp);
      if (done_exp) begin
        checkOutput({tag, "_done_busy"}, o_busy, 0);
        seen_done = 1;
        stop      = 1;
      end
      if (pe_valid_exp) checkOutput({tag, "_pe_valid"}, o_pe_valid, 1);
      if (o_pe_valid) begin
        if (first_valid < 0) first_valid = cycles;
        checkOutput({tag, "_beat_expected"}, exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          front = exp_q[0];
          checkOutput({tag, "_addr"}, o_weight_addr, front.addr);
          checkOutput({tag, "_k"}, o_kernel_step, front.k);
          checkOutput({tag, "_c"}, o_channel_step, front.c);
          checkOutput({tag, "_last"}, o_last_channel_step, front.last);
          checkOutput({tag, "_data"}, o_pe_data, front.data);
        end
        if (!i_pe_ready) checkOutput({tag, "_stall_act_ready"}, o_act_ready, 0);
      end

      act_fire = o_act_ready && i_act_valid;
      pe_fire  = o_pe_valid && i_pe_ready;
      if (act_fire) begin
        checkOutput({tag, "_extra_act"}, next_idx < groups, 1);
        next_idx++;
      end
      done_exp = 0;
      if (pe_fire && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        fired++;
        last_fire = cycles;
        done_exp  = (exp_q.size() == 0);
      end
      pe_valid_exp = act_fire || (o_pe_valid && !pe_fire);

      if (abort_after >= 0 && fired == abort_after) begin
        aborted = 1;
        stop    = 1;
      end
      cycles++;
      if (cycles > CYCLE_LIMIT) stop = 1;
      if (!stop) @(negedge clk);
    end

    if (aborted) begin
      @(negedge clk);
      reset       = 1'b1;
      i_act_valid = 1'b0;
      i_pe_ready  = 1'b0;
      @(negedge clk);
      check_all_zero({tag, "_abort"});
      reset = 1'b0;
      @(negedge clk);
      checkOutput({tag, "_post_abort_done"}, o_done, 0);
      checkOutput({tag, "_post_abort_busy"}, o_busy, 0);
    end else begin
      checkOutput({tag, "_seen_done"}, seen_done, 1);
      checkOutput({tag, "_groups_taken"}, next_idx, groups);
      if (ready_mode == 0 && valid_mode == 0)
        checkOutput({tag, "_no_bubble_span"}, last_fire - first_valid + 1, total_beats);
      @(negedge clk);
      i_start     = 1'b0;
      i_act_valid = 1'b0;
      #1;
      checkOutput({tag, "_after_done_busy"}, o_busy, 0);
      checkOutput({tag, "_after_done_pulse"}, o_done, 0);
      checkOutput({tag, "_after_done_pe_valid"}, o_pe_valid, 0);
      checkOutput({tag, "_after_done_act_ready"}, o_act_ready, 0);
    end
  endtask

  initial begin
    reset               = 1'b1;
    i_start             = 1'b0;
    i_num_kernel_steps  = '0;
    i_num_channel_steps = '0;
    i_num_pixels        = '0;
    i_act_data          = '0;
    i_act_valid         = 1'b0;
    i_pe_ready          = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    applyStimulus("k3c2p1", 3, 2, 1, 0, 0, -1, 1'b0);
    applyStimulus("k1c1p4", 1, 1, 4, 0, 0, -1, 1'b0);
    applyStimulus("stall", 2, 2, 1, 2, 0, -1, 1'b0);

    bad_start("c_zero", 3, 0, 1);
    applyStimulus("after_bad", 2, 1, 2, 0, 1, -1, 1'b0);
    bad_start("k_zero", 0, 1, 1);
    bad_start("p_zero", 1, 1, 0);
    bad_start("too_deep", 64, 17, 1);

    applyStimulus("abort", 3, 2, 1, 0, 0, 3, 1'b0);
    applyStimulus("restart", 3, 2, 1, 0, 0, -1, 1'b1);
    applyStimulus("depth_edge", 32, 32, 1, 0, 0, -1, 1'b0);

    for (int i = 0; i < 6; i++)
      applyStimulus("random", $urandom_range(1, 4), $urandom_range(1, 4),
                    $urandom_range(1, 3), 1, 1, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
